// File: rtl/spi_core_if.sv
// Slot bus between the MMIO controller and the SPI master.
// The controller side drives strobes and data; the core returns rd_data.
interface spi_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, reg_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, reg_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/spi_core.sv
// Byte-wide full-duplex SPI master for MMIO slot 7.
// Software drives selects, divider and mode; it polls ready via rd_data.
module spi_core #(
  parameter int          SS_WIDTH = 2,
  parameter logic [15:0] DVSR_RST = 16'd199
) (
  input  logic                clk,
  input  logic                reset,
  spi_core_if.slave           bus,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [SS_WIDTH-1:0] spi_ss_n
);

  typedef enum logic [1:0] {
    IDLE,
    P0,
    P1
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         c_q, c_d;
  logic [2:0]          n_q, n_d;
  logic [7:0]          sh_q, sh_d;
  logic                mi_q, mi_d;
  logic [7:0]          rx_q, rx_d;
  logic [15:0]         dw_q, dw_d;
  logic                pw_q, pw_d;
  logic                hw_q, hw_d;
  logic [SS_WIDTH-1:0] ss_q;
  logic [15:0]         dvsr_q;
  logic                cpol_q;
  logic                cpha_q;

  logic wr_en, wr_ss, wr_ctl, wr_tx, last;
  logic unused_bits;

  assign wr_en  = bus.cs & bus.write;
  assign wr_ss  = wr_en && (bus.reg_addr == 5'd1);
  assign wr_ctl = wr_en && (bus.reg_addr == 5'd2);
  assign wr_tx  = wr_en && (bus.reg_addr == 5'd3);
  assign last   = (c_q == dw_q);

  assign unused_bits = ^{bus.read, bus.wr_data};

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    n_d     = n_q;
    sh_d    = sh_q;
    mi_d    = mi_q;
    rx_d    = rx_q;
    dw_d    = dw_q;
    pw_d    = pw_q;
    hw_d    = hw_q;
    unique case (state_q)
      IDLE: begin
        if (wr_tx) begin
          sh_d    = bus.wr_data[7:0];
          dw_d    = dvsr_q;
          pw_d    = cpol_q;
          hw_d    = cpha_q;
          c_d     = '0;
          n_d     = '0;
          state_d = P0;
        end
      end
      P0: begin
        if (last) begin
          mi_d    = spi_miso;
          c_d     = '0;
          state_d = P1;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      P1: begin
        if (last) begin
          c_d  = '0;
          sh_d = {sh_q[6:0], mi_q};
          if (n_q == 3'd7) begin
            rx_d    = {sh_q[6:0], mi_q};
            state_d = IDLE;
          end else begin
            n_d     = n_q + 3'd1;
            state_d = P0;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      mi_q    <= 1'b0;
      rx_q    <= '0;
      dw_q    <= DVSR_RST;
      pw_q    <= 1'b0;
      hw_q    <= 1'b0;
      ss_q    <= '1;
      dvsr_q  <= DVSR_RST;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      mi_q    <= mi_d;
      rx_q    <= rx_d;
      dw_q    <= dw_d;
      pw_q    <= pw_d;
      hw_q    <= hw_d;
      if (wr_ss)
        ss_q <= bus.wr_data[SS_WIDTH-1:0];
      if (wr_ctl) begin
        dvsr_q <= bus.wr_data[15:0];
        cpol_q <= bus.wr_data[16];
        cpha_q <= bus.wr_data[17];
      end
    end
  end

  // Idle level follows the live cpol so a mode change shows up at once.
  always_comb begin
    spi_sclk = cpol_q;
    if (state_q != IDLE)
      spi_sclk = pw_q ^ (hw_q ? (state_q == P0) : (state_q == P1));
  end

  assign spi_mosi    = (state_q != IDLE) & sh_q[7];
  assign spi_ss_n    = ss_q;
  assign bus.rd_data = {23'b0, state_q == IDLE, rx_q};

endmodule

// File: tb/tb_spi_core.sv
// Directed bench for spi_core: mode/divider vector table
// plus busy-drop, select, control-latch and reset sequences.
module tb_spi_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [1:0] spi_ss_n;

  spi_core_if bus ();

  spi_core #(
    .SS_WIDTH (2),
    .DVSR_RST (16'd199)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic       cur_cpol = 1'b0;
  logic       cur_cpha = 1'b0;
  logic [1:0] cur_ss = 2'b11;
  logic       loop_en = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int         edge_base = 0;

  int         mon_edges = 0;
  logic [7:0] tx_seen = 8'h00;
  logic [2:0] s_idx;

  // Bench-side slave: every master sampling edge moves to the next bit.
  always @(spi_sclk) begin
    if (spi_sclk === ~(cur_cpol ^ cur_cpha)) begin
      mon_edges <= mon_edges + 1;
      tx_seen   <= {tx_seen[6:0], spi_mosi};
    end
  end

  assign s_idx    = 3'(mon_edges - edge_base);
  assign spi_miso = loop_en ? spi_mosi : slave_byte[3'd7 - s_idx];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1;
    bus.reg_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] dv, input logic pol,
                     input logic pha, input logic [1:0] ss);
    cur_cpol = pol;
    cur_cpha = pha;
    cur_ss   = ss;
    bus_wr(5'd2, {14'b0, pha, pol, dv});
    bus_wr(5'd1, {30'b0, ss});
  endtask

  // Starts a transfer at the current negedge; one optional bus write
  // is injected k cycles later. Returns ready-low and sclk-active counts.
  task automatic xfer(input logic [7:0] tx, input int hk,
                      input logic [4:0] ha, input logic [31:0] hd,
                      output int low, output int act, output int ss_bad);
    logic       done;
    logic [1:0] exp_ss;
    low = 0; act = 0; ss_bad = 0; done = 1'b0;
    edge_base = mon_edges;
    bus.cs = 1'b1; bus.write = 1'b1;
    bus.reg_addr = 5'd3; bus.wr_data = {24'b0, tx};
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      bus.cs = (k == hk); bus.write = (k == hk);
      bus.reg_addr = ha; bus.wr_data = hd;
      exp_ss = (ha == 5'd1 && hk >= 0 && k > hk) ? hd[1:0] : cur_ss;
      if (spi_ss_n !== exp_ss) ss_bad++;
      if (bus.rd_data[8]) begin
        done = 1'b1;
        break;
      end
      low++;
      if (spi_sclk !== cur_cpol) act++;
    end
    bus.cs = 1'b0; bus.write = 1'b0;
    if (ha == 5'd1 && hk >= 0) cur_ss = hd[1:0];
    chk("xfer_timeout", {31'b0, done}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] dvsr;
    logic        cpol;
    logic        cpha;
    logic [1:0]  ss;
    logic [7:0]  tx;
    logic [7:0]  slv;
    logic        loop;
    logic [7:0]  exp_rx;
    int          exp_low;
    int          exp_act;
  } vec_t;

  vec_t vt[5];

  initial begin
    int low, act, ss_bad, busy;
    logic ok;

    vt[0] = '{16'd3, 1'b0, 1'b0, 2'b10, 8'hA5, 8'h00, 1'b1, 8'hA5, 64, 32};
    vt[1] = '{16'd0, 1'b1, 1'b1, 2'b01, 8'hFF, 8'h3C, 1'b0, 8'h3C, 16, 8};
    vt[2] = '{16'd1, 1'b0, 1'b1, 2'b01, 8'h5A, 8'hC3, 1'b0, 8'hC3, 32, 16};
    vt[3] = '{16'd2, 1'b1, 1'b0, 2'b10, 8'h81, 8'h7E, 1'b0, 8'h7E, 48, 24};
    vt[4] = '{16'd0, 1'b0, 1'b0, 2'b11, 8'h00, 8'hFF, 1'b1, 8'h00, 16, 8};

    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.reg_addr = '0; bus.wr_data = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data", bus.rd_data, 32'h100);
    chk("rst_ss_n", {30'b0, spi_ss_n}, 32'h3);
    chk("rst_sclk", {31'b0, spi_sclk}, 32'h0);
    chk("rst_mosi", {31'b0, spi_mosi}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      loop_en    = vt[i].loop;
      slave_byte = vt[i].slv;
      cfg(vt[i].dvsr, vt[i].cpol, vt[i].cpha, vt[i].ss);
      chk($sformatf("v%0d_idle_sclk", i), {31'b0, spi_sclk},
          {31'b0, vt[i].cpol});
      xfer(vt[i].tx, -1, 5'd0, 32'd0, low, act, ss_bad);
      chk($sformatf("v%0d_ready_low", i), low, vt[i].exp_low);
      chk($sformatf("v%0d_sclk_active", i), act, vt[i].exp_act);
      chk($sformatf("v%0d_edges", i), mon_edges - edge_base, 8);
      chk($sformatf("v%0d_mosi", i), {24'b0, tx_seen}, {24'b0, vt[i].tx});
      chk($sformatf("v%0d_ss", i), ss_bad, 0);
      chk($sformatf("v%0d_rd", i), bus.rd_data, {23'b0, 1'b1, vt[i].exp_rx});
    end

    // Start while busy must be dropped, and ready rises only once.
    loop_en = 1'b1;
    cfg(16'd0, 1'b0, 1'b0, 2'b11);
    xfer(8'h11, 4, 5'd3, 32'h22, low, act, ss_bad);
    chk("busy_low", low, 16);
    chk("busy_edges", mon_edges - edge_base, 8);
    chk("busy_mosi", {24'b0, tx_seen}, 32'h11);
    chk("busy_rd", bus.rd_data, 32'h111);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.rd_data[8]) busy++;
    end
    chk("busy_no_requeue", busy, 0);

    // Select write mid-transfer applies at once and the byte completes.
    cfg(16'd1, 1'b0, 1'b0, 2'b11);
    xfer(8'h3C, 6, 5'd1, 32'h1, low, act, ss_bad);
    chk("ssmid_ss", ss_bad, 0);
    chk("ssmid_low", low, 32);
    chk("ssmid_rd", bus.rd_data, 32'h13C);
    chk("ssmid_ss_after", {30'b0, spi_ss_n}, 32'h1);

    // Divider write mid-transfer only affects the following byte,
    // which is started in the very cycle ready rises.
    cfg(16'd3, 1'b0, 1'b0, 2'b10);
    xfer(8'h5A, 10, 5'd2, 32'h7, low, act, ss_bad);
    chk("latch1_low", low, 64);
    chk("latch1_act", act, 32);
    chk("latch1_rd", bus.rd_data, 32'h15A);
    xfer(8'h96, -1, 5'd0, 32'd0, low, act, ss_bad);
    chk("latch2_low", low, 128);
    chk("latch2_act", act, 64);
    chk("latch2_rd", bus.rd_data, 32'h196);

    // Reset after four bits have been exchanged.
    cfg(16'd3, 1'b0, 1'b0, 2'b10);
    edge_base = mon_edges;
    bus.cs = 1'b1; bus.write = 1'b1;
    bus.reg_addr = 5'd3; bus.wr_data = 32'hC3;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      bus.cs = 1'b0; bus.write = 1'b0;
      if (mon_edges - edge_base >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmid_reach_bit3", {31'b0, ok}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_rd", bus.rd_data, 32'h100);
    chk("rstmid_ss", {30'b0, spi_ss_n}, 32'h3);
    chk("rstmid_sclk", {31'b0, spi_sclk}, 32'h0);
    chk("rstmid_mosi", {31'b0, spi_mosi}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
